vreg_writeback: RTL and testbench
=================================

# vreg_writeback

Write-side companion of the vector/scalar register file: it merges ALU results and memory-load returns into the single register-file write port (`we3`, `ra3`, `wd3`, `selec_v_s_w`). Memory returns arrive one 32-bit word per beat, and vector loads are assembled lane by lane into a 16×32-bit vector before being written. The block sits between the execute/memory stages and the register file. It also exposes the in-flight load destination so decode can detect hazards.

## Interface
Parameters:
- `LANES`, 16: vector lanes; fixed at 16 to match the register file.
- `W`, 32: lane width in bits.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `alu_valid`  in  1: ALU result offered.
- `alu_ready`  out  1: ALU result accepted this cycle when high together with `alu_valid`.
- `alu_rd`  in  4: destination register.
- `alu_vec`  in  1: 1 selects a vector destination, 0 a scalar destination.
- `alu_data`  in  16×32: result; scalar results are carried in lane 15.
- `mem_valid`  in  1: memory word offered.
- `mem_ready`  out  1: memory word accepted when high together with `mem_valid`.
- `mem_rd`  in  4: destination; sampled on the first beat only.
- `mem_vec`  in  1: 1 means a 16-beat vector load, 0 a 1-beat scalar load; sampled on the first beat only.
- `mem_data`  in  32: load word.
- `we3`  out  1: register-file write enable.
- `ra3`  out  4: write address.
- `wd3`  out  16×32: write data.
- `selec_v_s_w`  out  1: 1 for a vector write, 0 for a scalar write.
- `pend_valid`  out  1: a load is collecting or waiting to be written.
- `pend_rd`  out  4: destination of the pending load.
- `pend_vec`  out  1: 1 if the pending load targets a vector register.
- `pc_drop`  out  1: one-cycle pulse when a scalar write to r15 is discarded.

## Operation
- Memory FSM states:
  - M_IDLE: `mem_ready`=1. An accepted beat latches `mem_rd`/`mem_vec` and writes lane 0 for a vector load or lane 15 for a scalar load. Next state is M_COLLECT with `cnt`=1 if vector, M_PEND if scalar.
  - M_COLLECT: `mem_ready`=1. Each accepted beat writes lane `cnt`, then `cnt`++. The beat with `cnt`==15 goes to M_PEND. Cycles without `mem_valid` hold state and count.
  - M_PEND: `mem_ready`=0. The buffer waits for the write slot. The cycle it is granted returns to M_IDLE.
- Write-port arbitration (one grant per cycle):
  - M_PEND has priority; `alu_ready`=0 in that cycle.
  - Otherwise `alu_ready`=1, and an ALU result with `alu_valid` is granted.
- Write formation for a granted source, registered:
  - `we3`=1, `ra3`=rd, `selec_v_s_w`=vec.
  - `wd3`=full data for a vector write.
  - `wd3`={data[15], lanes 14:0 = 0} for a scalar write.
- Scalar write to r15 (r15 is the PC, no scalar storage): the result is still accepted/consumed, but `we3` stays 0 and `pc_drop` pulses in the output cycle. A vector write to v15 is legal.
- Lanes of the collect buffer are cleared on entry to M_IDLE. Scalar loads therefore write zeros in lanes 14:0.
- `pend_valid`=1 from the cycle after the first accepted beat until the cycle after the grant. `pend_rd`/`pend_vec` hold the latched values and are 0 when not pending.
- No ordering is enforced between ALU and load writes to the same register. Decode stalls on `pend_*`.

## Timing
- Reset (synchronous, `rst` high at a rising edge):
  - FSM returns to M_IDLE, `cnt`=0, buffer cleared.
  - Outputs become `we3`=0, `ra3`=0, `wd3`=0, `selec_v_s_w`=0, `pend_valid`=0, `pend_rd`=0, `pend_vec`=0, `pc_drop`=0.
  - Reset mid-collect or in M_PEND discards the partial load; no write is issued.
  - `alu_ready`/`mem_ready` are 0 while `rst` is high.
- ALU latency: accepted at edge N → `we3` high for exactly cycle N+1.
- Load latency: last beat accepted at edge N → M_PEND during N+1 → granted at edge N+1 → `we3` during N+2. A vector load occupies ≥17 cycles from first beat to write.
- `we3` is a single-cycle pulse per write. Back-to-back ALU writes give continuous `we3`.
- Outputs are stable for a full cycle around the register file's falling-edge write.
- Simultaneous `alu_valid` and the last memory beat: the ALU is granted that cycle, and the load is written the following cycle.

## Test plan
- Reset, then ALU vector write `alu_rd`=3, lanes = lane index → `we3`=1 one cycle later, `ra3`=3, `selec_v_s_w`=1, `wd3[k]`=k; `alu_ready` high throughout.
- Vector load to v2: 16 beats of 100+k with gaps after beats 4 and 9 → a single write with `wd3[k]`=100+k, `ra3`=2; `pend_valid` high from beat 1 until the write cycle; `mem_ready` low during M_PEND.
- Scalar load to r7 with data 0xDEAD → `selec_v_s_w`=0, `wd3[15]`=0xDEAD, `wd3[14:0]`=0.
- ALU scalar write to r15 → `we3` stays 0, `pc_drop` pulses once, `alu_ready`=1; an ALU vector write to v15 produces `we3`=1.
- ALU held valid while a load completes → the load write preempts, `alu_ready`=0 for that one cycle, the ALU write follows on the next cycle with no gap.
- `rst` asserted after beat 8 of a vector load → no write; a fresh load issued afterwards lands its first beat in lane 0 and writes the correct data.

Source files
------------

// File: rtl/vreg_writeback_if.sv
//==============================================================================
// Module      : vreg_writeback_if
// Description : ALU/memory handshakes, register-file write port and hazard
//               outputs of the vector register write-back stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vreg_writeback_if #(
    parameter int LANES = 16,
    parameter int W     = 32
);
    logic                    alu_valid;
    logic                    alu_ready;
    logic [3:0]              alu_rd;
    logic                    alu_vec;
    logic [LANES-1:0][W-1:0] alu_data;

    logic                    mem_valid;
    logic                    mem_ready;
    logic [3:0]              mem_rd;
    logic                    mem_vec;
    logic [W-1:0]            mem_data;

    logic                    we3;
    logic [3:0]              ra3;
    logic [LANES-1:0][W-1:0] wd3;
    logic                    selec_v_s_w;

    logic                    pend_valid;
    logic [3:0]              pend_rd;
    logic                    pend_vec;
    logic                    pc_drop;

    modport master (
        output alu_valid, alu_rd, alu_vec, alu_data,
        output mem_valid, mem_rd, mem_vec, mem_data,
        input  alu_ready, mem_ready,
        input  we3, ra3, wd3, selec_v_s_w,
        input  pend_valid, pend_rd, pend_vec, pc_drop
    );

    modport slave (
        input  alu_valid, alu_rd, alu_vec, alu_data,
        input  mem_valid, mem_rd, mem_vec, mem_data,
        output alu_ready, mem_ready,
        output we3, ra3, wd3, selec_v_s_w,
        output pend_valid, pend_rd, pend_vec, pc_drop
    );
endinterface

`default_nettype wire

// File: rtl/vreg_writeback.sv
//==============================================================================
// Module      : vreg_writeback
// Description : Merges ALU results and beat-wise memory loads into the single
//               register-file write port; exposes the in-flight load target.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vreg_writeback #(
    parameter int LANES = 16,
    parameter int W     = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vreg_writeback_if.slave bus
);
    typedef enum logic [1:0] {
        M_IDLE    = 2'd0,
        M_COLLECT = 2'd1,
        M_PEND    = 2'd2
    } mstate_e;

    localparam logic [3:0] PC_REG    = 4'd15;
    localparam logic [3:0] LAST_LANE = 4'(LANES - 1);

    mstate_e                 state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              rd_q, rd_d;
    logic                    vec_q, vec_d;
    logic [LANES-1:0][W-1:0] buf_q, buf_d;
    logic                    pend_q, pend_d;

    logic                    we3_q, we3_d;
    logic [3:0]              ra3_q, ra3_d;
    logic [LANES-1:0][W-1:0] wd3_q, wd3_d;
    logic                    sel_q, sel_d;
    logic                    drop_q, drop_d;

    logic                    ready_w;
    logic                    mem_acc_w;
    logic                    alu_acc_w;
    logic                    mem_grant_w;
    logic                    g_valid_w;
    logic                    g_vec_w;
    logic                    g_drop_w;
    logic [3:0]              g_rd_w;
    logic [LANES-1:0][W-1:0] g_data_w;

    // A completed load owns the write slot, so both inputs stall that cycle.
    assign mem_grant_w = (state_q == M_PEND);
    assign ready_w     = !rst && !mem_grant_w;
    assign mem_acc_w   = bus.mem_valid && ready_w;
    assign alu_acc_w   = bus.alu_valid && ready_w;

    assign bus.alu_ready   = ready_w;
    assign bus.mem_ready   = ready_w;
    assign bus.we3         = we3_q;
    assign bus.ra3         = ra3_q;
    assign bus.wd3         = wd3_q;
    assign bus.selec_v_s_w = sel_q;
    assign bus.pc_drop     = drop_q;
    assign bus.pend_valid  = pend_q;
    assign bus.pend_rd     = pend_q ? rd_q : 4'd0;
    assign bus.pend_vec    = pend_q && vec_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        vec_d   = vec_q;
        buf_d   = buf_q;
        case (state_q)
            M_IDLE: begin
                if (mem_acc_w) begin
                    rd_d  = bus.mem_rd;
                    vec_d = bus.mem_vec;
                    if (bus.mem_vec) begin
                        buf_d[0] = bus.mem_data;
                        cnt_d    = 4'd1;
                        state_d  = M_COLLECT;
                    end else begin
                        buf_d[LAST_LANE] = bus.mem_data;
                        state_d          = M_PEND;
                    end
                end
            end
            M_COLLECT: begin
                if (mem_acc_w) begin
                    buf_d[cnt_q] = bus.mem_data;
                    if (cnt_q == LAST_LANE) begin
                        cnt_d   = 4'd0;
                        state_d = M_PEND;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            M_PEND: begin
                // Always granted here; clearing keeps the next scalar load's low lanes zero.
                buf_d   = '0;
                state_d = M_IDLE;
            end
            default: begin
                buf_d   = '0;
                cnt_d   = 4'd0;
                state_d = M_IDLE;
            end
        endcase
    end

    // Pending stays visible through the write cycle itself.
    assign pend_d = (state_d != M_IDLE) || (state_q == M_PEND);

    always_comb begin
        g_valid_w = mem_grant_w || alu_acc_w;
        g_rd_w    = mem_grant_w ? rd_q  : bus.alu_rd;
        g_vec_w   = mem_grant_w ? vec_q : bus.alu_vec;
        g_data_w  = mem_grant_w ? buf_q : bus.alu_data;
        g_drop_w  = g_valid_w && !g_vec_w && (g_rd_w == PC_REG);

        we3_d  = g_valid_w && !g_drop_w;
        drop_d = g_drop_w;
        ra3_d  = ra3_q;
        sel_d  = sel_q;
        wd3_d  = wd3_q;
        if (we3_d) begin
            ra3_d = g_rd_w;
            sel_d = g_vec_w;
            if (g_vec_w) begin
                wd3_d = g_data_w;
            end else begin
                wd3_d            = '0;
                wd3_d[LAST_LANE] = g_data_w[LAST_LANE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 4'd0;
            vec_q   <= 1'b0;
            buf_q   <= '0;
            pend_q  <= 1'b0;
            we3_q   <= 1'b0;
            ra3_q   <= 4'd0;
            wd3_q   <= '0;
            sel_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            vec_q   <= vec_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            we3_q   <= we3_d;
            ra3_q   <= ra3_d;
            wd3_q   <= wd3_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_vreg_writeback.sv
//==============================================================================
// Module      : tb_vreg_writeback
// Description : Scoreboard bench for vreg_writeback with a transaction-level
//               load/ALU reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vreg_writeback;
    typedef logic [15:0][31:0] vec_t;

    typedef struct {
        int unsigned ecyc;
        logic        drop;
        logic [3:0]  rd;
        logic        vec;
        vec_t        data;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          errors;
    int          checks;
    exp_t        sbq[$];

    // reference model of the load path
    logic        m_active;
    logic        m_wait;
    logic        m_wflag;
    int          m_cnt;
    logic [3:0]  m_rd;
    logic        m_vec;
    vec_t        m_lanes;

    vreg_writeback_if bus ();

    vreg_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int unsigned ec, input logic [3:0] rd,
                                     input logic vec, input vec_t src);
        exp_t e;
        e.ecyc = ec;
        e.rd   = rd;
        e.vec  = vec;
        e.drop = !vec && (rd == 4'd15);
        if (vec) begin
            e.data = src;
        end else begin
            e.data     = '0;
            e.data[15] = src[15];
        end
        sbq.push_back(e);
    endfunction

    // Observer: checks handshake/pending outputs, then models accepted traffic.
    initial begin
        m_active = 0; m_wait = 0; m_wflag = 0; m_cnt = 0;
        m_rd = '0; m_vec = 0; m_lanes = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("alu_ready_in_rst", bus.alu_ready, 1'b0);
                chk("mem_ready_in_rst", bus.mem_ready, 1'b0);
                m_active = 0; m_wait = 0; m_wflag = 0; m_cnt = 0;
                while (sbq.size() > 0 && sbq[$].ecyc > cyc) void'(sbq.pop_back());
            end else begin
                chk("alu_ready", bus.alu_ready, !m_wait);
                chk("mem_ready", bus.mem_ready, !m_wait);
                chk("pend_valid", bus.pend_valid, m_active || m_wflag);
                chk("pend_rd", bus.pend_rd, (m_active || m_wflag) ? m_rd : 4'd0);
                chk("pend_vec", bus.pend_vec, (m_active || m_wflag) && m_vec);
                m_wflag = 0;
                if (m_wait) begin
                    push_exp(cyc + 1, m_rd, m_vec, m_lanes);
                    m_wait   = 0;
                    m_active = 0;
                    m_wflag  = 1;
                end
                if (bus.alu_valid && bus.alu_ready)
                    push_exp(cyc + 1, bus.alu_rd, bus.alu_vec, bus.alu_data);
                if (bus.mem_valid && bus.mem_ready) begin
                    if (!m_active) begin
                        m_active = 1;
                        m_rd     = bus.mem_rd;
                        m_vec    = bus.mem_vec;
                        m_lanes  = '0;
                        if (bus.mem_vec) begin
                            m_lanes[0] = bus.mem_data;
                            m_cnt      = 1;
                        end else begin
                            m_lanes[15] = bus.mem_data;
                            m_wait      = 1;
                        end
                    end else begin
                        m_lanes[m_cnt] = bus.mem_data;
                        m_cnt++;
                        if (m_cnt == 16) m_wait = 1;
                    end
                end
            end
        end
    end

    // Monitor: every write-port event must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].ecyc < cyc) begin
                e = sbq.pop_front();
                chk("missing_write_rd", 5'h10, {1'b0, e.rd});
            end
            if (bus.we3 || bus.pc_drop) begin
                if (sbq.size() == 0 || sbq[0].ecyc != cyc) begin
                    chk("unexpected_write", {bus.we3, bus.pc_drop}, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    chk("we3", bus.we3, !e.drop);
                    chk("pc_drop", bus.pc_drop, e.drop);
                    if (!e.drop) begin
                        chk("ra3", bus.ra3, e.rd);
                        chk("selec_v_s_w", bus.selec_v_s_w, e.vec);
                        chk("wd3", bus.wd3, e.data);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic alu_send(input logic [3:0] rd, input logic vec, input vec_t d);
        bit ok;
        ok = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_vec   = vec;
        bus.alu_data  = d;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.alu_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("alu_accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b0;
    endtask

    task automatic mem_beat(input logic [3:0] rd, input logic vec, input logic [31:0] d);
        bit ok;
        ok = 0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = rd;
        bus.mem_vec   = vec;
        bus.mem_data  = d;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.mem_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("mem_accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
    endtask

    // Later beats carry junk rd/vec: only the first beat's values may matter.
    task automatic mem_load(input logic [3:0] rd, input logic vec, input vec_t d,
                            input logic [15:0] gapm, input int gap);
        int nb;
        nb = vec ? 16 : 1;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) mem_beat(rd, vec, vec ? d[k] : d[15]);
            else        mem_beat(4'($urandom), 1'($urandom), d[k]);
            if (gapm[k]) idle(gap);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < 16; k++) v[k] = $urandom;
        return v;
    endfunction

    initial begin
        vec_t d;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_vec = 1'b0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_vec = 1'b0; bus.mem_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we3", bus.we3, 1'b0);
        chk("rst_ra3", bus.ra3, 4'd0);
        chk("rst_wd3", bus.wd3, '0);
        chk("rst_sel", bus.selec_v_s_w, 1'b0);
        chk("rst_pend_valid", bus.pend_valid, 1'b0);
        chk("rst_pend_rd", bus.pend_rd, 4'd0);
        chk("rst_pend_vec", bus.pend_vec, 1'b0);
        chk("rst_pc_drop", bus.pc_drop, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU vector write, lanes = lane index
        for (int k = 0; k < 16; k++) d[k] = k;
        alu_send(4'd3, 1'b1, d);
        idle(2);

        // vector load v2 with gaps after beats 4 and 9
        for (int k = 0; k < 16; k++) d[k] = 100 + k;
        mem_load(4'd2, 1'b1, d, 16'h0108, 2);
        idle(4);

        // scalar load r7; lanes below 15 must come back zero
        d = rand_vec();
        d[15] = 32'hDEAD;
        mem_load(4'd7, 1'b0, d, 16'h0000, 0);
        idle(3);

        // scalar r15 is dropped, vector v15 is written
        alu_send(4'd15, 1'b0, rand_vec());
        alu_send(4'd15, 1'b1, rand_vec());
        idle(2);

        // ALU arrives with the last beat, then is held across the load's write slot
        fork
            mem_load(4'd9, 1'b1, rand_vec(), 16'h0000, 0);
            begin
                idle(15);
                repeat (3) alu_send(4'($urandom_range(0, 14)), 1'($urandom), rand_vec());
            end
        join
        idle(4);

        // reset after beat 8 discards the partial load
        d = rand_vec();
        for (int k = 0; k < 8; k++) mem_beat(4'd4, 1'b1, d[k]);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        mem_load(4'd5, 1'b1, rand_vec(), 16'h0000, 0);
        idle(4);

        // randomized concurrent traffic
        fork
            for (int i = 0; i < 40; i++) begin
                alu_send(4'($urandom), 1'($urandom), rand_vec());
                idle($urandom_range(0, 2));
            end
            for (int i = 0; i < 8; i++) begin
                mem_load(4'($urandom), 1'($urandom), rand_vec(), 16'($urandom), 1);
                idle($urandom_range(0, 2));
            end
        join

        idle(10);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
